// File: rtl/spi_flash_rd_seq.sv
// SPI NOR READ (0x03) sequencer: drives the SPI master's register port to send
// command, 24-bit address and dummy bytes, and returns each data-phase byte as a strobe.
module spi_flash_rd_seq #(
   parameter logic [31:0] SPI_BASE = 32'h0,
   parameter logic [7:0]  CLK_DIV  = 8'd0,
   parameter logic        CPOL     = 1'b0,
   parameter logic        CPHA     = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic [23:0] req_addr_i,
   input  logic [7:0]  req_len_i,
   output logic        busy_o,
   output logic        rvalid_o,
   output logic [7:0]  rdata_o,
   output logic        done_o,
   output logic [31:0] spi_addr_o,
   output logic [31:0] spi_wdata_o,
   output logic        spi_we_o,
   input  logic [31:0] spi_rdata_i
);

   localparam logic [31:0] CTRL_A = {SPI_BASE[31:4], 4'h0};
   localparam logic [31:0] DATA_A = {SPI_BASE[31:4], 4'h4};
   localparam logic [31:0] STAT_A = {SPI_BASE[31:4], 4'h8};

   typedef enum logic [3:0] {
      IDLE, SEL, LOAD, START, SETTLE, POLL, CAPTURE, DESEL, DONE
   } state_t;

   state_t      state_q, state_d;
   logic [8:0]  idx_q, idx_d;
   logic [8:0]  len_q, len_d;
   logic [23:0] addr_q, addr_d;
   logic        settle_q, settle_d;
   logic        busy_q, busy_d;
   logic        rvalid_q, rvalid_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        done_q, done_d;
   logic [31:0] spi_addr_q, spi_addr_d;
   logic [31:0] spi_wdata_q, spi_wdata_d;
   logic        spi_we_q, spi_we_d;

   function automatic logic [31:0] ctrl_word(input logic ss, input logic start);
      return {16'h0, CLK_DIV, 4'h0, ss, CPHA, CPOL, start};
   endfunction

   function automatic logic [7:0] tx_byte(input logic [8:0] idx, input logic [23:0] a);
      case (idx)
         9'd0:    return 8'h03;
         9'd1:    return a[23:16];
         9'd2:    return a[15:8];
         9'd3:    return a[7:0];
         default: return 8'h00;
      endcase
   endfunction

   // Next-state logic; bus outputs are computed for the state being entered so they register cleanly.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      addr_d      = addr_q;
      settle_d    = settle_q;
      busy_d      = busy_q;
      rvalid_d    = 1'b0;
      rdata_d     = rdata_q;
      done_d      = 1'b0;
      spi_addr_d  = spi_addr_q;
      spi_wdata_d = spi_wdata_q;
      spi_we_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               state_d     = SEL;
               addr_d      = req_addr_i;
               len_d       = (req_len_i == 8'd0) ? 9'd256 : {1'b0, req_len_i};
               idx_d       = 9'd0;
               busy_d      = 1'b1;
               spi_we_d    = 1'b1;
               spi_addr_d  = CTRL_A;
               spi_wdata_d = ctrl_word(1'b1, 1'b0);
            end else begin
               state_d = IDLE;
            end
         end
         SEL: begin
            state_d     = LOAD;
            spi_we_d    = 1'b1;
            spi_addr_d  = DATA_A;
            spi_wdata_d = {24'h0, tx_byte(idx_q, addr_q)};
         end
         LOAD: begin
            state_d     = START;
            spi_we_d    = 1'b1;
            spi_addr_d  = CTRL_A;
            spi_wdata_d = ctrl_word(1'b1, 1'b1);
         end
         START: begin
            state_d     = SETTLE;
            settle_d    = 1'b0;
            spi_addr_d  = STAT_A;
            spi_wdata_d = 32'h0;
         end
         SETTLE: begin
            // SPI busy shows up two cycles after the start write
            if (settle_q) begin
               state_d = POLL;
            end else begin
               settle_d = 1'b1;
            end
         end
         POLL: begin
            if (!spi_rdata_i[0]) begin
               state_d    = CAPTURE;
               spi_addr_d = DATA_A;
            end else begin
               state_d = POLL;
            end
         end
         CAPTURE: begin
            if (idx_q >= 9'd4) begin
               rvalid_d = 1'b1;
               rdata_d  = spi_rdata_i[7:0];
            end else begin
               rvalid_d = 1'b0;
            end
            if (idx_q == len_q + 9'd3) begin
               state_d     = DESEL;
               spi_we_d    = 1'b1;
               spi_addr_d  = CTRL_A;
               spi_wdata_d = 32'h0;
            end else begin
               state_d     = LOAD;
               idx_d       = idx_q + 9'd1;
               spi_we_d    = 1'b1;
               spi_addr_d  = DATA_A;
               spi_wdata_d = {24'h0, tx_byte(idx_q + 9'd1, addr_q)};
            end
         end
         DESEL: begin
            state_d     = DONE;
            spi_addr_d  = SPI_BASE;
            spi_wdata_d = 32'h0;
         end
         DONE: begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end
         default: begin
            state_d     = IDLE;
            busy_d      = 1'b0;
            spi_addr_d  = SPI_BASE;
            spi_wdata_d = 32'h0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         idx_q       <= 9'd0;
         len_q       <= 9'd0;
         addr_q      <= 24'h0;
         settle_q    <= 1'b0;
         busy_q      <= 1'b0;
         rvalid_q    <= 1'b0;
         rdata_q     <= 8'h0;
         done_q      <= 1'b0;
         spi_addr_q  <= SPI_BASE;
         spi_wdata_q <= 32'h0;
         spi_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         len_q       <= len_d;
         addr_q      <= addr_d;
         settle_q    <= settle_d;
         busy_q      <= busy_d;
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
         spi_addr_q  <= spi_addr_d;
         spi_wdata_q <= spi_wdata_d;
         spi_we_q    <= spi_we_d;
      end
   end

   assign busy_o      = busy_q;
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rdata_q;
   assign done_o      = done_q;
   assign spi_addr_o  = spi_addr_q;
   assign spi_wdata_o = spi_wdata_q;
   assign spi_we_o    = spi_we_q;

endmodule

// File: tb/tb_spi_flash_rd_seq.sv
// Bench for spi_flash_rd_seq: behavioural SPI register model with 2-cycle busy lag
// plus flash responder, directed transactions with hand-computed expectations.
module tb_spi_flash_rd_seq;

   localparam logic [31:0] BASE  = 32'h4000_0000;
   localparam logic [31:0] SEL_W = 32'h0000_030E;
   localparam logic [31:0] STA_W = 32'h0000_030F;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req = 1'b0;
   logic [23:0] req_addr = 24'h0;
   logic [7:0]  req_len = 8'h0;
   logic        busy_o, rvalid_o, done_o, spi_we_o;
   logic [7:0]  rdata_o;
   logic [31:0] spi_addr_o, spi_wdata_o, spi_rdata_i;

   spi_flash_rd_seq #(.SPI_BASE(BASE), .CLK_DIV(8'd3), .CPOL(1'b1), .CPHA(1'b1)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_addr_i(req_addr), .req_len_i(req_len),
      .busy_o(busy_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o), .done_o(done_o),
      .spi_addr_o(spi_addr_o), .spi_wdata_o(spi_wdata_o), .spi_we_o(spi_we_o),
      .spi_rdata_i(spi_rdata_i)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // SPI master register model
   logic [31:0] m_ctrl = 32'h0;
   logic [7:0]  m_tx = 8'h0;
   logic [7:0]  m_rx = 8'h0;
   logic        m_busy = 1'b0;
   int          m_lag = 0;
   int          m_cnt = 0;
   int          m_sess = 0;
   logic [23:0] m_addr = 24'h0;
   logic [23:0] flash_base = 24'h0;
   logic [7:0]  mosi_q[$];

   function automatic logic [7:0] rx_of(input int sess);
      logic [23:0] off;
      if (sess < 4) return 8'hFF;
      off = m_addr + 24'(sess - 4) - flash_base;
      return 8'hA0 + off[7:0];
   endfunction

   always_comb begin
      case (spi_addr_o[3:0])
         4'h0:    spi_rdata_i = m_ctrl;
         4'h4:    spi_rdata_i = {24'h0, m_rx};
         4'h8:    spi_rdata_i = {31'h0, m_busy};
         default: spi_rdata_i = 32'h0;
      endcase
   end

   always @(posedge clk) begin
      if (m_lag != 0) begin
         m_lag <= m_lag - 1;
         if (m_lag == 1) begin
            m_busy <= 1'b1;
            m_cnt  <= 18 * (int'(m_ctrl[15:8]) + 1);
         end
      end else if (m_busy) begin
         if (m_cnt == 1) begin
            m_busy <= 1'b0;
            m_rx   <= rx_of(m_sess);
            m_sess <= m_sess + 1;
            mosi_q.push_back(m_tx);
            if (m_sess == 1) m_addr[23:16] <= m_tx;
            if (m_sess == 2) m_addr[15:8]  <= m_tx;
            if (m_sess == 3) m_addr[7:0]   <= m_tx;
         end else begin
            m_cnt <= m_cnt - 1;
         end
      end
      if (spi_we_o && spi_addr_o[3:0] == 4'h0) begin
         m_ctrl <= {spi_wdata_o[31:1], 1'b0};
         if (spi_wdata_o[0]) m_lag <= 2;
         if (!spi_wdata_o[3]) m_sess <= 0;
      end
      if (spi_we_o && spi_addr_o[3:0] == 4'h4) m_tx <= spi_wdata_o[7:0];
   end

   // Output monitor, sampled on the falling edge
   int         cyc = 0;
   int         desel_cyc = 0;
   int         done_gap = 0;
   int         first_done_cyc = 0;
   int         done_cnt = 0;
   int         early_cap = 0;
   int         ss_err = 0;
   int         sel_q[$];
   logic [7:0] rv_q[$];

   always @(negedge clk) begin
      cyc++;
      if (spi_we_o && spi_addr_o == BASE && spi_wdata_o == 32'h0) desel_cyc = cyc;
      if (spi_we_o && spi_addr_o == BASE && spi_wdata_o == SEL_W) sel_q.push_back(cyc);
      if (!spi_we_o && spi_addr_o == BASE + 32'h4 && (m_busy || m_lag != 0)) early_cap++;
      if (rvalid_o) begin
         rv_q.push_back(rdata_o);
         if (!m_ctrl[3]) ss_err++;
      end
      if (done_o) begin
         if (done_cnt == 0) first_done_cyc = cyc;
         done_cnt++;
         done_gap = cyc - desel_cyc;
         if (m_ctrl[3]) ss_err++;
      end
   end

   task automatic clear_mon(input logic [23:0] fb);
      flash_base = fb;
      mosi_q.delete();
      rv_q.delete();
      sel_q.delete();
      done_cnt = 0;
      early_cap = 0;
      ss_err = 0;
   endtask

   task automatic start_req(input logic [23:0] a, input logic [7:0] l, input logic hold);
      @(posedge clk); #1;
      req_addr = a;
      req_len = l;
      req = 1'b1;
      @(posedge clk); #1;
      if (!hold) req = 1'b0;
      chk("sel_we", {31'h0, spi_we_o}, 32'h1);
      chk("sel_addr", spi_addr_o, BASE);
      chk("sel_wdata", spi_wdata_o, SEL_W);
      chk("sel_busy", {31'h0, busy_o}, 32'h1);
      @(posedge clk); #1;
      chk("load_wdata", spi_wdata_o, 32'h3);
      @(posedge clk); #1;
      chk("start_wdata", spi_wdata_o, STA_W);
   endtask

   task automatic wait_done(input int n, input int bound);
      int k = 0;
      while (done_cnt < n && k < bound) begin
         @(posedge clk);
         k++;
      end
      #1;
      chk("done_seen", done_cnt, n);
   endtask

   task automatic check_txn(input logic [23:0] a, input logic [7:0] l);
      int len = (l == 8'd0) ? 256 : int'(l);
      int bad = 0;
      logic [7:0] e;
      repeat (6) @(posedge clk);
      #1;
      chk("mosi_len", mosi_q.size(), len + 4);
      for (int k = 0; k < mosi_q.size(); k++) begin
         case (k)
            0: e = 8'h03;
            1: e = a[23:16];
            2: e = a[15:8];
            3: e = a[7:0];
            default: e = 8'h00;
         endcase
         if (mosi_q[k] !== e) bad++;
      end
      chk("mosi_data", bad, 0);
      chk("rv_len", rv_q.size(), len);
      bad = 0;
      for (int k = 0; k < rv_q.size(); k++) begin
         e = 8'hA0 + 8'(k);
         if (rv_q[k] !== e) bad++;
      end
      chk("rv_data", bad, 0);
      chk("done_once", done_cnt, 1);
      chk("done_gap", done_gap, 2);
      chk("early_poll", early_cap, 0);
      chk("ss_held", ss_err, 0);
      chk("idle_busy", {31'h0, busy_o}, 32'h0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'h0, busy_o}, 32'h0);
      chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
      chk("rst_rdata", {24'h0, rdata_o}, 32'h0);
      chk("rst_done", {31'h0, done_o}, 32'h0);
      chk("rst_we", {31'h0, spi_we_o}, 32'h0);
      chk("rst_addr", spi_addr_o, BASE);
      chk("rst_wdata", spi_wdata_o, 32'h0);
      rst = 1'b0;

      // basic 4-byte read
      clear_mon(24'h012345);
      start_req(24'h012345, 8'd4, 1'b0);
      wait_done(1, 2000);
      check_txn(24'h012345, 8'd4);

      // len 0 means 256 bytes
      clear_mon(24'h000000);
      start_req(24'h000000, 8'd0, 1'b0);
      wait_done(1, 40000);
      check_txn(24'h000000, 8'd0);

      // top of address space
      clear_mon(24'hFFFFFE);
      start_req(24'hFFFFFE, 8'd2, 1'b0);
      wait_done(1, 2000);
      check_txn(24'hFFFFFE, 8'd2);

      // request pulsed mid-transaction is ignored
      clear_mon(24'h012345);
      start_req(24'h012345, 8'd4, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      req_addr = 24'h0ABCDE;
      req_len = 8'd9;
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      chk("repulse_busy", {31'h0, busy_o}, 32'h1);
      wait_done(1, 2000);
      check_txn(24'h012345, 8'd4);

      // req held high: back-to-back transactions
      clear_mon(24'h000100);
      start_req(24'h000100, 8'd2, 1'b1);
      wait_done(1, 2000);
      @(posedge clk); #1;
      req = 1'b0;
      wait_done(2, 2000);
      repeat (4) @(posedge clk);
      #1;
      chk("b2b_sel_cnt", sel_q.size(), 2);
      if (sel_q.size() == 2) chk("b2b_sel_gap", sel_q[1] - first_done_cyc, 1);
      chk("b2b_rv_len", rv_q.size(), 4);
      if (rv_q.size() == 4) begin
         chk("b2b_rv0", {24'h0, rv_q[2]}, 32'hA0);
         chk("b2b_rv1", {24'h0, rv_q[3]}, 32'hA1);
      end

      // reset during third dummy byte
      clear_mon(24'h012345);
      start_req(24'h012345, 8'd4, 1'b0);
      begin
         int k = 0;
         while (rv_q.size() < 2 && k < 2000) begin
            @(posedge clk);
            k++;
         end
      end
      #1;
      chk("pre_rst_rv", rv_q.size(), 2);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_busy", {31'h0, busy_o}, 32'h0);
      chk("mid_rst_we", {31'h0, spi_we_o}, 32'h0);
      chk("mid_rst_rvalid", {31'h0, rvalid_o}, 32'h0);
      chk("mid_rst_addr", spi_addr_o, BASE);
      repeat (300) @(posedge clk);
      #1;
      chk("mid_rst_no_done", done_cnt, 0);
      chk("mid_rst_no_rv", rv_q.size(), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_flash_rd_seq.md
# spi_flash_rd_seq

Hardware sequencer that runs a complete SPI NOR "READ (0x03)" transaction through the `spi` master's register port, so the core does not have to bit-bang it. It sits between a simple request port (boot loader / instruction prefetch) and the SPI master's `addr_i/data_i/we_i/data_o` bus. It drives the chip select, command, 24-bit address and N dummy bytes. Each byte received in the data phase is returned as a one-cycle strobe.

## Interface
- `SPI_BASE`, 32'h0: base address placed in `spi_addr_o[31:4]`; offsets are CTRL 0x0, DATA 0x4, STATUS 0x8.
- `CLK_DIV`, 8'd0: value written to SPI ctrl[15:8].
- `CPOL`, 1'b0: value written to ctrl[1].
- `CPHA`, 1'b0: value written to ctrl[2].
- `clk_i` in 1: clock.
- `rst_i` in 1: reset; one clock, reset is synchronous and active-high.
- `req_i` in 1: start request.
- `req_addr_i` in 24: flash byte address.
- `req_len_i` in 8: bytes to read; 0 means 256.
- `busy_o` out 1: transaction in progress.
- `rvalid_o` out 1: one-cycle strobe, `rdata_o` valid.
- `rdata_o` out 8: received data byte.
- `done_o` out 1: one-cycle pulse after chip select is released.
- `spi_addr_o` out 32: to SPI `addr_i`.
- `spi_wdata_o` out 32: to SPI `data_i`.
- `spi_we_o` out 1: to SPI `we_i`.
- `spi_rdata_i` in 32: from SPI `data_o`, combinational on `spi_addr_o`.

## Operation
- CTRL word = {16'h0, CLK_DIV, 4'h0, ss, CPHA, CPOL, start}. Every CTRL write is a full 32-bit write.
- States:
  - IDLE -> SEL when `req_i` is high.
  - SEL: write CTRL with ss=1, start=0 -> LOAD.
  - LOAD: write DATA = {24'h0, tx_byte} -> START.
  - START: write CTRL with ss=1, start=1 -> SETTLE.
  - SETTLE: 2 cycles, `spi_we_o`=0, `spi_addr_o`=STATUS -> POLL.
  - POLL: address STATUS, read-only; if `spi_rdata_i[0]` is 0 -> CAPTURE, otherwise stay.
  - CAPTURE: address DATA; if in the data phase, `rdata_o` <= `spi_rdata_i[7:0]` and pulse `rvalid_o`. Then go to LOAD if bytes remain, otherwise DESEL.
  - DESEL: write CTRL = 32'h0 -> DONE.
  - DONE: pulse `done_o` -> IDLE.
- SETTLE is mandatory. The SPI busy status lags the start write by 2 cycles, so polling earlier would see a stale idle.
- `spi_we_o` is high only in SEL, LOAD, START and DESEL. This guarantees the SPI start bit self-clears on the cycle after START.
- Byte sequence: 0x03, A[23:16], A[15:8], A[7:0], then L dummy bytes of 0x00.
  - L = `req_len_i`, or 256 when `req_len_i` is 0.
  - Byte index counter is 9 bits wide, range 0..L+3.
  - Command and address bytes produce no `rvalid_o`.
- Request handling:
  - `req_addr_i` and `req_len_i` are latched on the IDLE cycle where `req_i` is high.
  - `req_i` is ignored while `busy_o` is high.
  - If `req_i` is still high in the cycle after DONE, a new transaction starts. This is legal.
- No backpressure. The consumer must accept every `rvalid_o` strobe.

## Timing
- Reset values: `busy_o`=0, `rvalid_o`=0, `rdata_o`=0, `done_o`=0, `spi_we_o`=0, `spi_addr_o`=SPI_BASE, `spi_wdata_o`=0. State = IDLE.
- `busy_o` is high from the cycle after acceptance through the DONE cycle inclusive.
- Request to first SPI write (SEL): 1 cycle.
- Per byte: LOAD 1 + START 1 + SETTLE 2 + POLL (≥1, roughly 18·(CLK_DIV+1)) + CAPTURE 1.
- `rvalid_o` is asserted in the cycle after CAPTURE is entered (registered).
- `done_o` is asserted exactly 2 cycles after the DESEL write, and only once per transaction.
- `rst_i` mid-transaction: next cycle the block is in IDLE with all outputs at reset values, and no `done_o` is generated.
  - The SPI peripheral keeps its own state.
  - The system resets both blocks together. Standalone sequencer reset is legal only with the SPI idle.

## Test plan
- Basic read: `spi` instance plus a flash model holding 0xA0+i at address 0x012345+i; CPOL=0, CPHA=0, CLK_DIV=0; request addr 0x012345, len 4.
  - MOSI shows 03 01 23 45 00 00 00 00.
  - `rvalid_o` strobes 4 times with A0 A1 A2 A3.
  - `spi_ss` is low throughout and high before `done_o`.
- len 0 from address 0x000000 -> 256 strobes with data 0xA0+i mod 256, then exactly one `done_o`.
- CPOL=1, CPHA=1, CLK_DIV=3, len 2 at address 0xFFFFFE -> bytes A0 A1 correct; no POLL exit occurs before SPI busy has been observed low after SETTLE.
- Request pulsed again mid-transaction with a different address -> ignored; only the original 4 bytes are returned; `busy_o` stays high.
- `req_i` held high continuously -> two back-to-back transactions; the second SEL write occurs 1 cycle after the first `done_o`.
- `rst_i` asserted during the third dummy byte -> next cycle `busy_o`=0 and `spi_we_o`=0, with no `done_o` and no further `rvalid_o`.
